// File: rtl/regfile_write_controller.sv
// rtl/regfile_write_controller.sv - 32x32 register file with round-robin write port sharing and dump engine (optional: RF_BYPASS_EN)
module regfile_write_controller #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              dump_req,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] dump_ptr_q, dump_ptr_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              last_grant_b_q, last_grant_b_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic commit;
    logic slot_free;

    // Arbitration: a single staging slot, freed either when empty or when it drains this cycle.
    // The slot drains in any state but DUMP, so the DONE beat already resumes commits.
    always_comb begin
        commit    = pend_valid_q && (state_q != ST_DUMP);
        slot_free = !pend_valid_q || commit;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        if (slot_free) begin
            if (a_valid && !b_valid) begin
                a_ready = 1'b1;
            end else if (b_valid && !a_valid) begin
                b_ready = 1'b1;
            end else if (a_valid && b_valid) begin
                if (last_grant_b_q) begin
                    a_ready = 1'b1;
                end else begin
                    b_ready = 1'b1;
                end
            end
        end
    end

    // Staging slot next state: drain on commit, refill from whichever requester was accepted.
    always_comb begin
        pend_valid_d   = pend_valid_q;
        pend_addr_d    = pend_addr_q;
        pend_data_d    = pend_data_q;
        last_grant_b_d = last_grant_b_q;
        if (commit) begin
            pend_valid_d = 1'b0;
        end
        if (a_valid && a_ready) begin
            pend_valid_d   = 1'b1;
            pend_addr_d    = a_addr;
            pend_data_d    = a_data;
            last_grant_b_d = 1'b0;
        end else if (b_valid && b_ready) begin
            pend_valid_d   = 1'b1;
            pend_addr_d    = b_addr;
            pend_data_d    = b_data;
            last_grant_b_d = 1'b1;
        end
    end

    // Dump sequencer next state and beat outputs; the pointer wraps to 0 on the last beat.
    always_comb begin
        state_d    = state_q;
        dump_ptr_d = dump_ptr_q;
        dump_valid = 1'b0;
        dump_addr  = '0;
        dump_data  = '0;
        dump_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dump_req) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                dump_valid = 1'b1;
                dump_addr  = dump_ptr_q;
                dump_data  = regs_q[dump_ptr_q];
                dump_ptr_d = dump_ptr_q + 1'b1;
                if (dump_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                dump_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers; last grant starts at B so A wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            dump_ptr_q     <= '0;
            pend_valid_q   <= 1'b0;
            pend_addr_q    <= '0;
            pend_data_q    <= '0;
            last_grant_b_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            dump_ptr_q     <= dump_ptr_d;
            pend_valid_q   <= pend_valid_d;
            pend_addr_q    <= pend_addr_d;
            pend_data_q    <= pend_data_d;
            last_grant_b_q <= last_grant_b_d;
        end
    end

    // Register array: commits to r0 still drain the slot but never land, keeping r0 at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit && (pend_addr_q != '0)) begin
            regs_q[pend_addr_q] <= pend_data_q;
        end
    end

    // Asynchronous read ports, optionally forwarding the staged write.
    always_comb begin
        rd_data0 = (rd_addr0 == '0) ? '0 : regs_q[rd_addr0];
        rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
`ifdef RF_BYPASS_EN
        if (pend_valid_q && (pend_addr_q == rd_addr0) && (rd_addr0 != '0)) begin
            rd_data0 = pend_data_q;
        end
        if (pend_valid_q && (pend_addr_q == rd_addr1) && (rd_addr1 != '0)) begin
            rd_data1 = pend_data_q;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_write_controller.sv
// tb/tb_regfile_write_controller.sv - directed and random checks of regfile_write_controller against a reference model
module tb_regfile_write_controller;

    logic        clk;
    logic        reset;
    logic        a_valid, a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [4:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic        dump_req, dump_valid, dump_done;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    regfile_write_controller #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_done(dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents, writes accepted but not yet landed, grant history, dump progress.
    logic [31:0] m_mem [32];
    logic [4:0]  mq_addr [$];
    logic [31:0] mq_data [$];
    bit          m_last_b;
    int          m_mode;   // 0 idle, 1 dumping, 2 dump finished
    int          m_idx;

    logic        obs_ar, obs_br, obs_dv, obs_dd;
    logic [4:0]  obs_da;
    logic [31:0] obs_ddata, obs_rd0, obs_rd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        mq_addr.delete();
        mq_data.delete();
        m_last_b = 1'b1;
        m_mode   = 0;
        m_idx    = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (mq_addr.size() != 0 && mq_addr[0] == a) return mq_data[0];
`endif
        return m_mem[a];
    endfunction

    // One clock: called at a falling edge with inputs applied; checks outputs, then advances the model.
    task automatic cycle();
        bit stall, do_commit, free, ea, eb;
        #1;
        obs_ar = a_ready; obs_br = b_ready; obs_dv = dump_valid; obs_dd = dump_done;
        obs_da = dump_addr; obs_ddata = dump_data; obs_rd0 = rd_data0; obs_rd1 = rd_data1;
        stall     = (m_mode == 1);
        do_commit = (mq_addr.size() != 0) && !stall;
        free      = (mq_addr.size() == 0) || do_commit;
        ea = free && a_valid && (!b_valid || m_last_b);
        eb = free && b_valid && (!a_valid || !m_last_b);
        chk("a_ready", 32'(a_ready), 32'(ea));
        chk("b_ready", 32'(b_ready), 32'(eb));
        chk("one_ready", 32'(a_ready & b_ready), 32'd0);
        chk("rd_data0", rd_data0, model_read(rd_addr0));
        chk("rd_data1", rd_data1, model_read(rd_addr1));
        chk("dump_valid", 32'(dump_valid), 32'(m_mode == 1));
        chk("dump_done", 32'(dump_done), 32'(m_mode == 2));
        if (m_mode == 1) begin
            chk("dump_addr", 32'(dump_addr), 32'(m_idx));
            chk("dump_data", dump_data, m_mem[m_idx]);
        end
        @(posedge clk);
        if (do_commit) begin
            if (mq_addr[0] != 5'd0) m_mem[mq_addr[0]] = mq_data[0];
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
        end
        if (ea) begin
            mq_addr.push_back(a_addr); mq_data.push_back(a_data); m_last_b = 1'b0;
        end else if (eb) begin
            mq_addr.push_back(b_addr); mq_data.push_back(b_data); m_last_b = 1'b1;
        end
        case (m_mode)
            0: if (dump_req) begin m_mode = 1; m_idx = 0; end
            1: if (m_idx == 31) begin m_mode = 2; m_idx = 0; end else m_idx++;
            default: m_mode = 0;
        endcase
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, done_at, seen;
        reset = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        rd_addr0 = 0; rd_addr1 = 0; dump_req = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        rd_addr0 = 5'd7; rd_addr1 = 5'd31;
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_done", 32'(dump_done), 32'd0);
        chk("rst_dump_addr", 32'(dump_addr), 32'd0);
        chk("rst_dump_data", dump_data, 32'd0);
        chk("rst_rd0", rd_data0, 32'd0);
        chk("rst_rd1", rd_data1, 32'd0);
        @(negedge clk);

        // Dump of a freshly reset file.
        beats = 0; done_at = -1;
        for (int k = 0; k < 40; k++) begin
            dump_req = (k == 0);
            cycle();
            if (obs_dv) begin
                chk("t1_beat_addr", 32'(obs_da), 32'(beats));
                chk("t1_beat_data", obs_ddata, 32'd0);
                beats++;
            end
            if (obs_dd) done_at = k;
        end
        dump_req = 0;
        chk("t1_beats", 32'(beats), 32'd32);
        chk("t1_done_cycle", 32'(done_at), 32'd33);

        // Write latency for a single A request.
        a_valid = 1; a_addr = 5'd3; a_data = 32'hDEADBEEF; rd_addr0 = 5'd3;
        cycle();
        chk("t2_accept", 32'(obs_ar), 32'd1);
        a_valid = 0;
        cycle();
`ifdef RF_BYPASS_EN
        chk("t2_rd_n1", obs_rd0, 32'hDEADBEEF);
`else
        chk("t2_rd_n1", obs_rd0, 32'd0);
`endif
        cycle();
        chk("t2_rd_n2", obs_rd0, 32'hDEADBEEF);

        // Both requesters contending: last grant was A, so B leads the alternation.
        a_valid = 1; a_addr = 5'd1; b_valid = 1; b_addr = 5'd2;
        for (int i = 0; i < 8; i++) begin
            a_data = 32'hA0000000 + 32'(i);
            b_data = 32'hB0000000 + 32'(i);
            cycle();
            chk("t3_b_turn", 32'(obs_br), 32'((i % 2) == 0));
            chk("t3_a_turn", 32'(obs_ar), 32'((i % 2) == 1));
        end
        a_valid = 0; b_valid = 0; rd_addr0 = 5'd1; rd_addr1 = 5'd2;
        cycle(); cycle();
        chk("t3_r1", obs_rd0, 32'hA0000007);
        chk("t3_r2", obs_rd1, 32'hB0000006);

        // Writes to r0 complete the handshake but are discarded.
        b_valid = 1; b_addr = 5'd0; b_data = 32'hFFFFFFFF; rd_addr1 = 5'd0;
        cycle();
        chk("t4_accept", 32'(obs_br), 32'd1);
        b_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_r0", obs_rd1, 32'd0);
        end

        // Write staged at dump start: dump shows the old value, write lands afterwards.
        a_valid = 1; a_addr = 5'd5; a_data = 32'h11;
        cycle();
        a_valid = 0;
        cycle(); cycle();
        dump_req = 1; b_valid = 1; b_addr = 5'd5; b_data = 32'h22;
        cycle();
        chk("t5_b_accept", 32'(obs_br), 32'd1);
        dump_req = 0; b_addr = 5'd6; b_data = 32'h66;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            cycle();
            if (obs_dv) chk("t5_b_stall", 32'(obs_br), 32'd0);
            if (obs_dv && obs_da == 5'd5) chk("t5_beat5", obs_ddata, 32'h11);
            if (obs_dd) seen = 1;
        end
        chk("t5_done_seen", 32'(seen), 32'd1);
        b_valid = 0; rd_addr0 = 5'd5; rd_addr1 = 5'd6;
        cycle(); cycle();
        chk("t5_r5", obs_rd0, 32'h22);
        chk("t5_r6", obs_rd1, 32'h66);

        // Asynchronous reset in the middle of a dump, with a write held in the slot.
        dump_req = 1;
        cycle();
        dump_req = 0; a_valid = 1; a_addr = 5'd7; a_data = 32'h77;
        cycle();
        a_valid = 0;
        for (int k = 0; k < 64 && !(m_mode == 1 && m_idx == 10); k++) cycle();
        #1;
        chk("t6_at_ptr10_valid", 32'(dump_valid), 32'd1);
        chk("t6_at_ptr10_addr", 32'(dump_addr), 32'd10);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_valid_drop", 32'(dump_valid), 32'd0);
        chk("t6_done_low", 32'(dump_done), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i);
            cycle();
            chk("t6_cleared", obs_rd0, 32'd0);
            chk("t6_no_done", 32'(obs_dd), 32'd0);
        end

        // Random traffic over a small address window to force r0 hits, collisions and dumps.
        for (int i = 0; i < 600; i++) begin
            a_valid  = 1'($urandom_range(1, 0));
            a_addr   = 5'($urandom_range(7, 0));
            a_data   = $urandom;
            b_valid  = 1'($urandom_range(1, 0));
            b_addr   = 5'($urandom_range(7, 0));
            b_data   = $urandom;
            rd_addr0 = 5'($urandom_range(7, 0));
            rd_addr1 = 5'($urandom_range(31, 0));
            dump_req = ($urandom_range(39, 0) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
